// File: rtl/pixel_parallelizer_if.sv
// AXI-Stream style bus used for both the pixel input and the burst output.
interface pixel_parallelizer_if #(
    parameter int DW = 100,
    parameter int UW = 2
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;

    modport master (output tvalid, tdata, tuser, input tready);
    modport slave  (input tvalid, tdata, tuser, output tready);
endinterface

// File: rtl/pixel_parallelizer.sv
// Packs a frame-aligned serial pixel stream into wide bursts of PIXELS_PER_BURST
// lanes, tagging first/last bursts of a frame and flagging mid-frame resyncs.
module pixel_parallelizer #(
    parameter int PIXEL_BIT_WIDTH  = 10,
    parameter int PIXELS_PER_BURST = 10,
    parameter int USER_WIDTH       = 2,
    parameter int FRAME_ROWS       = 20,
    parameter int FRAME_COLS       = 20,
    localparam int ROW_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1,
    localparam int COL_W = (FRAME_COLS > 1) ? $clog2(FRAME_COLS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_parallelizer_if.slave   s_axis,
    pixel_parallelizer_if.master  m_axis,
    output logic [ROW_W-1:0]      m_row,
    output logic [COL_W-1:0]      m_col,
    output logic                  frame_done,
    output logic                  sof_error
);
    localparam int PW    = PIXEL_BIT_WIDTH;
    localparam int N     = PIXELS_PER_BURST;
    localparam int UW    = USER_WIDTH;
    localparam int TOTAL = FRAME_ROWS * FRAME_COLS;
    localparam int LW    = (N > 1) ? $clog2(N) : 1;
    localparam int PCW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [LW-1:0]    LANE_LAST = LW'(N - 1);
    localparam logic [PCW-1:0]   PIX_LAST  = PCW'(TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(FRAME_COLS - 1);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] PACK     = 1'b1;

    logic [0:0]       state;
    logic [LW-1:0]    lane_cnt;
    logic [PCW-1:0]   pix_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;

    // lanes 0..N-2 wait here; lane N-1 goes straight into the output word
    logic [N-2:0][PW-1:0] collect;
    logic                 first_l0;
    logic [UW-1:0]        user_l0;
    logic [ROW_W-1:0]     row_l0;
    logic [COL_W-1:0]     col_l0;

    logic [N-1:0][PW-1:0] word_q;
    logic [UW-1:0]        user_q;
    logic                 valid_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;

    logic             sof, hs, take, mid_sof, load, frame_end, drain;
    logic [LW-1:0]    lane_w;
    logic [PCW-1:0]   pix_w;
    logic [ROW_W-1:0] row_w;
    logic [COL_W-1:0] col_w;
    logic [UW-1:0]    out_user;

    // A held full word only blocks the pixel that would overwrite it (lane N-1).
    assign s_axis.tready = !reset & ((state == WAIT_SOF) | (lane_cnt != LANE_LAST)
                                     | !valid_q | m_axis.tready);

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = word_q;
    assign m_axis.tuser  = user_q;
    assign m_row         = row_q;
    assign m_col         = col_q;

    // Decode the current handshake; an SOF pixel always restarts at lane 0 / pixel 0.
    always_comb begin
        sof       = s_axis.tuser[0];
        hs        = s_axis.tvalid & s_axis.tready;
        take      = hs & (sof | (state == PACK));
        mid_sof   = hs & sof & (state == PACK);
        lane_w    = sof ? '0 : lane_cnt;
        pix_w     = sof ? '0 : pix_cnt;
        row_w     = sof ? '0 : row_cnt;
        col_w     = sof ? '0 : col_cnt;
        load      = take & (lane_w == LANE_LAST);
        frame_end = take & (pix_w == PIX_LAST);
        drain     = valid_q & m_axis.tready;
        // sideband bits come from the lane-0 pixel, low two bits are the frame tags
        out_user    = user_l0;
        out_user[0] = first_l0;
        out_user[1] = frame_end;
    end

    // Frame FSM and lane/pixel/row/col counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_SOF;
            lane_cnt <= '0;
            pix_cnt  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (take) begin
            if (frame_end) begin
                state    <= WAIT_SOF;
                lane_cnt <= '0;
                pix_cnt  <= '0;
                row_cnt  <= '0;
                col_cnt  <= '0;
            end else begin
                state    <= PACK;
                pix_cnt  <= pix_w + 1'b1;
                lane_cnt <= (lane_w == LANE_LAST) ? '0 : lane_w + 1'b1;
                if (col_w == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_w == ROW_LAST) ? '0 : row_w + 1'b1;
                end else begin
                    col_cnt <= col_w + 1'b1;
                    row_cnt <= row_w;
                end
            end
        end
    end

    // Collect lanes 0..N-2 and remember the lane-0 pixel's tags and coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            collect  <= '0;
            first_l0 <= 1'b0;
            user_l0  <= '0;
            row_l0   <= '0;
            col_l0   <= '0;
        end else if (take) begin
            for (int k = 0; k < N - 1; k++) begin
                if (lane_w == LW'(k)) collect[k] <= s_axis.tdata;
            end
            if (lane_w == '0) begin
                first_l0 <= (pix_w == '0);
                user_l0  <= s_axis.tuser;
                row_l0   <= row_w;
                col_l0   <= col_w;
            end
        end
    end

    // Output word: load on the last lane, otherwise drop valid once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            user_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            word_q  <= {s_axis.tdata, collect};
            user_q  <= out_user;
            row_q   <= row_l0;
            col_q   <= col_l0;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            sof_error  <= 1'b0;
        end else begin
            frame_done <= drain & user_q[1];
            sof_error  <= mid_sof;
        end
    end
endmodule

// File: tb/tb_pixel_parallelizer.sv
// Bench: two instances (4x4 and 2x8 frames, N=4) fed the same pixel stream,
// checked against a spec-level scoreboard plus a table of frame-1 bursts.
module tb_pixel_parallelizer;
    localparam int PW = 10;
    localparam int N  = 4;
    localparam int UW = 2;

    typedef struct {
        logic [PW*N-1:0] data;
        logic [1:0]      user;
        int              row;
        int              col;
        int              brow;
        int              bcol;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_data  = '0;
    logic [UW-1:0] s_user  = '0;
    logic          m_ready = 1'b0;

    pixel_parallelizer_if #(.DW(PW),   .UW(UW)) sa ();
    pixel_parallelizer_if #(.DW(PW*N), .UW(UW)) ma ();
    pixel_parallelizer_if #(.DW(PW),   .UW(UW)) sb ();
    pixel_parallelizer_if #(.DW(PW*N), .UW(UW)) mb ();

    assign sa.tvalid = s_valid;
    assign sa.tdata  = s_data;
    assign sa.tuser  = s_user;
    assign sb.tvalid = s_valid;
    assign sb.tdata  = s_data;
    assign sb.tuser  = s_user;
    assign ma.tready = m_ready;
    assign mb.tready = m_ready;

    logic [1:0] a_row, a_col;
    logic       a_fd, a_se;
    logic [0:0] b_row;
    logic [2:0] b_col;
    logic       b_fd, b_se;

    pixel_parallelizer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(N), .USER_WIDTH(UW),
                         .FRAME_ROWS(4), .FRAME_COLS(4)) dut_a (
        .clk(clk), .reset(rst), .s_axis(sa), .m_axis(ma),
        .m_row(a_row), .m_col(a_col), .frame_done(a_fd), .sof_error(a_se));

    pixel_parallelizer #(.PIXEL_BIT_WIDTH(PW), .PIXELS_PER_BURST(N), .USER_WIDTH(UW),
                         .FRAME_ROWS(2), .FRAME_COLS(8)) dut_b (
        .clk(clk), .reset(rst), .s_axis(sb), .m_axis(mb),
        .m_row(b_row), .m_col(b_col), .frame_done(b_fd), .sof_error(b_se));

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   stalls = 0;
    int   fd_cnt = 0;
    int   se_cnt = 0;
    bit   in_reset = 1'b1;
    bit   rand_ready = 1'b0;
    bit   cap_en = 1'b0;
    bit   fd_exp = 1'b0;
    bit   sofe_exp = 1'b0;
    exp_t q[$];
    exp_t cap[$];
    exp_t tab[4];

    // reference model state (spec level: frame position by pixel index)
    bit            md_state = 1'b0;
    int            md_lane = 0;
    int            md_pix = 0;
    int            md_l0 = 0;
    logic [PW-1:0] mc[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        md_state = 1'b0; md_lane = 0; md_pix = 0; md_l0 = 0;
        q.delete();
        fd_exp = 1'b0; sofe_exp = 1'b0;
    endtask

    // model of one accepted pixel; pushes the expected burst when lane N-1 fills
    task automatic model_accept(input logic [PW-1:0] d, input logic sof);
        exp_t e;
        if (!sof && !md_state) return;
        if (sof) begin
            if (md_state) sofe_exp = 1'b1;
            md_pix = 0; md_lane = 0; md_state = 1'b1;
        end
        mc[md_lane] = d;
        if (md_lane == 0) md_l0 = md_pix;
        if (md_lane == N - 1) begin
            e.data = {mc[3], mc[2], mc[1], mc[0]};
            e.user = {md_pix == 15, md_l0 == 0};
            e.row  = md_l0 / 4;  e.col  = md_l0 % 4;
            e.brow = md_l0 / 8;  e.bcol = md_l0 % 8;
            q.push_back(e);
        end
        md_lane = (md_lane + 1) % N;
        if (md_pix == 15) begin
            md_state = 1'b0; md_pix = 0; md_lane = 0;
        end else begin
            md_pix++;
        end
    endtask

    task automatic send(input logic [PW-1:0] d, input logic sof);
        bit ok = 1'b0;
        bit rdy;
        s_valid = 1'b1; s_data = d; s_user = {1'b0, sof};
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            rdy = sa.tready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            if (rdy) begin
                model_accept(d, sof);
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: pixel %0h never accepted", d);
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 16; i++) send(PW'(base + i), i == 0);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bursts still expected", q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_tvalid"}, ma.tvalid, 0);
        chk({tag, "_a_tready"}, sa.tready, 0);
        chk({tag, "_a_tdata"},  ma.tdata, 0);
        chk({tag, "_a_tuser"},  ma.tuser, 0);
        chk({tag, "_a_rowcol"}, {a_row, a_col}, 0);
        chk({tag, "_a_pulses"}, {a_fd, a_se}, 0);
        chk({tag, "_b_all"},    {mb.tvalid, sb.tready, mb.tdata, mb.tuser, b_row, b_col, b_fd, b_se}, 0);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        rst = 1'b1; in_reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check_zero(tag);
        model_clear();
        rst = 1'b0; in_reset = 1'b0;
    endtask

    // per-cycle monitor: valid/ready law, pulses, and scoreboard pop on handshake
    initial begin
        exp_t e, a;
        bit   expv;
        bit   exp_rdy;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                expv    = (q.size() != 0);
                exp_rdy = !md_state || (md_lane != N - 1) || !expv || m_ready;
                chk("a_tvalid", ma.tvalid, expv);
                chk("b_tvalid", mb.tvalid, expv);
                chk("a_tready", sa.tready, exp_rdy);
                chk("b_tready", sb.tready, exp_rdy);
                chk("frame_done", {a_fd, b_fd}, {fd_exp, fd_exp});
                chk("sof_error", {a_se, b_se}, {sofe_exp, sofe_exp});
                if (a_fd) fd_cnt++;
                if (a_se) se_cnt++;
                fd_exp = 1'b0;
                sofe_exp = 1'b0;
                if (expv && m_ready) begin
                    e = q.pop_front();
                    chk("a_tdata", ma.tdata, e.data);
                    chk("a_tuser", ma.tuser, e.user);
                    chk("a_row", a_row, e.row);
                    chk("a_col", a_col, e.col);
                    chk("b_tdata", mb.tdata, e.data);
                    chk("b_tuser", mb.tuser, e.user);
                    chk("b_row", b_row, e.brow);
                    chk("b_col", b_col, e.bcol);
                    if (e.user[1]) fd_exp = 1'b1;
                    if (cap_en) begin
                        a.data = ma.tdata; a.user = ma.tuser;
                        a.row = int'(a_row); a.col = int'(a_col);
                        a.brow = int'(b_row); a.bcol = int'(b_col);
                        cap.push_back(a);
                    end
                end
            end
        end
    end

    // output-side ready: fixed or random per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_ready = 1'(($urandom_range(0, 1)));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        // frame-1 expectations: lane k of burst b = 4b+k; 4x4 and 2x8 coordinates
        tab[0] = '{ {10'd3,  10'd2,  10'd1,  10'd0},  2'b01, 0, 0, 0, 0 };
        tab[1] = '{ {10'd7,  10'd6,  10'd5,  10'd4},  2'b00, 1, 0, 0, 4 };
        tab[2] = '{ {10'd11, 10'd10, 10'd9,  10'd8},  2'b00, 2, 0, 1, 0 };
        tab[3] = '{ {10'd15, 10'd14, 10'd13, 10'd12}, 2'b10, 3, 0, 1, 4 };

        do_reset(3, "reset");

        // 1: full-rate frame, back to back
        m_ready = 1'b1; stalls = 0; fd_cnt = 0; cap_en = 1'b1;
        send_frame(0);
        wait_drain();
        cap_en = 1'b0;
        chk("t1_no_stall", stalls, 0);
        chk("t1_frame_done_cnt", fd_cnt, 1);
        chk("t1_burst_cnt", cap.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap.size()) begin
                chk("tab_data", cap[i].data, tab[i].data);
                chk("tab_user", cap[i].user, tab[i].user);
                chk("tab_a_rowcol", {cap[i].row, cap[i].col}, {tab[i].row, tab[i].col});
                chk("tab_b_rowcol", {cap[i].brow, cap[i].bcol}, {tab[i].brow, tab[i].bcol});
            end
        end

        // 2: random downstream backpressure, two frames
        rand_ready = 1'b1; fd_cnt = 0;
        send_frame(100);
        send_frame(200);
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b1;
        chk("t2_frame_done_cnt", fd_cnt, 2);

        // 3: pixels before any SOF are dropped
        send(10'h1F0, 1'b0); send(10'h1F1, 1'b0); send(10'h1F2, 1'b0);
        send_frame(0);
        wait_drain();

        // 4: SOF arrives at frame pixel 6
        se_cnt = 0;
        for (int i = 0; i < 6; i++) send(PW'(i), i == 0);
        send_frame(6);
        wait_drain();
        chk("t4_sof_error_cnt", se_cnt, 1);

        // 5: reset while a word is held and a partial burst is collecting
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(PW'(300 + i), i == 0);
        @(negedge clk);
        chk("t5_held_valid", ma.tvalid, 1);
        @(posedge clk); #1;
        do_reset(1, "t5_reset");
        m_ready = 1'b1; fd_cnt = 0;
        send_frame(40);
        wait_drain();
        chk("t5_frame_done_cnt", fd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
